lvt_bram_arbiter: RTL and testbench

LVT_BRAM_ARBITER -- requirements
Module: lvt_bram_arbiter

---
 rtl/lvt_bram_pkg.sv | 27 ++
 rtl/lvt_bram_arbiter_rr_pick4.sv | 18 +
 rtl/lvt_bram_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_lvt_bram_arbiter.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvt_bram_pkg.sv
// Shared definitions for the LVT BRAM arbiter: FSM states, requester counts
// and the rotating-priority pick used by every arbitration point.
package lvt_bram_pkg;

    localparam int N_WR = 4;
    localparam int N_RD = 2;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Returns {found, index} of the first set bit of req at or after ptr, wrapping.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lvt_bram_arbiter_rr_pick4.sv
// Four-way rotating-priority picker; requesters set in i_excl are never chosen.
module rr_pick4
    import lvt_bram_pkg::*;
(
    input  logic [3:0] i_req,
    input  logic [3:0] i_excl,
    input  logic [1:0] i_ptr,
    output logic       o_found,
    output logic [1:0] o_idx
);

    logic [2:0] w_pick;

    assign w_pick  = rr_pick(i_req & ~i_excl, i_ptr);
    assign o_found = w_pick[2];
    assign o_idx   = w_pick[1:0];

endmodule

// File: rtl/lvt_bram_arbiter.sv
// Arbitrates 4 write and 2 read requesters onto a 2W/1R BRAM, and clears the
// whole memory (both write ports, one half each) after reset or on request.
module lvt_bram_arbiter
    import lvt_bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 wr_req_valid,
    output logic [3:0]                 wr_req_ready,
    input  logic [4*ADDR_WIDTH-1:0]    wr_req_addr,
    input  logic [4*DATA_WIDTH-1:0]    wr_req_data,
    input  logic [1:0]                 rd_req_valid,
    output logic [1:0]                 rd_req_ready,
    input  logic [2*ADDR_WIDTH-1:0]    rd_req_addr,
    output logic [1:0]                 rd_rsp_valid,
    output logic [DATA_WIDTH-1:0]      rd_rsp_data,
    input  logic                       clr_req,
    output logic                       init_done,
    output logic [ADDR_WIDTH-1:0]      wr0_addr,
    output logic [ADDR_WIDTH-1:0]      wr1_addr,
    output logic [DATA_WIDTH-1:0]      wr0_data,
    output logic [DATA_WIDTH-1:0]      wr1_data,
    output logic                       wr0_en,
    output logic                       wr1_en,
    output logic [ADDR_WIDTH-1:0]      rd0_addr,
    output logic                       rd0_en,
    input  logic [DATA_WIDTH-1:0]      rd0_data
);

    localparam int HALF_W = ADDR_WIDTH - 1;

    state_t              r_state;
    logic [HALF_W-1:0]   r_cnt;
    logic [1:0]          r_wp;
    logic                r_rp;
    logic [N_RD-1:0]     r_rsp_vld_p1;

    logic                w_run;
    logic                w_init_en;
    logic [ADDR_WIDTH-1:0] w_waddr [N_WR];
    logic [DATA_WIDTH-1:0] w_wdata [N_WR];
    logic [ADDR_WIDTH-1:0] w_raddr [N_RD];

    logic [N_WR-1:0]     w_wreq;
    logic [N_WR-1:0]     w_wreq1;
    logic [N_WR-1:0]     w_same;
    logic                w_g0;
    logic                w_g1;
    logic [1:0]          w_i0;
    logic [1:0]          w_i1;
    logic [1:0]          w_i0_nxt;
    logic [N_WR-1:0]     w_wgrant;
    logic [1:0]          w_wp_nxt;

    logic [N_RD-1:0]     w_rreq;
    logic                w_rgrant_any;
    logic                w_rsel;
    logic [N_RD-1:0]     w_rgrant;

    for (genvar gi = 0; gi < N_WR; gi++) begin : g_wr_unpack
        assign w_waddr[gi] = wr_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata[gi] = wr_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar gj = 0; gj < N_RD; gj++) begin : g_rd_unpack
        assign w_raddr[gj] = rd_req_addr[gj*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // A clear request in RUN suppresses every grant in that same cycle.
    assign w_run     = (r_state == ST_RUN) && !clr_req;
    assign w_init_en = (r_state == ST_INIT) && !rst;

    assign w_wreq = w_run ? wr_req_valid : '0;

    rr_pick4 u_pick_wr0 (
        .i_req   (w_wreq),
        .i_excl  (4'b0000),
        .i_ptr   (r_wp),
        .o_found (w_g0),
        .o_idx   (w_i0)
    );

    always_comb begin
        w_same = '0;
        for (int i = 0; i < N_WR; i++) begin
            w_same[i] = (w_waddr[i] == w_waddr[w_i0]);
        end
    end

    // Port 1 searches onward from port 0's winner, skipping any requester
    // that targets port 0's address (port 0's winner included).
    assign w_wreq1  = w_g0 ? w_wreq : '0;
    assign w_i0_nxt = w_i0 + 2'd1;

    rr_pick4 u_pick_wr1 (
        .i_req   (w_wreq1),
        .i_excl  (w_same),
        .i_ptr   (w_i0_nxt),
        .o_found (w_g1),
        .o_idx   (w_i1)
    );

    always_comb begin
        w_wgrant = '0;
        if (w_g0) begin
            w_wgrant[w_i0] = 1'b1;
        end
        if (w_g1) begin
            w_wgrant[w_i1] = 1'b1;
        end
    end

    always_comb begin
        w_wp_nxt = r_wp;
        if (w_g1) begin
            w_wp_nxt = w_i1 + 2'd1;
        end else if (w_g0) begin
            w_wp_nxt = w_i0_nxt;
        end
    end

    // Reads that collide with a write issued this cycle retry next cycle.
    always_comb begin
        w_rreq = '0;
        for (int j = 0; j < N_RD; j++) begin
            w_rreq[j] = w_run && rd_req_valid[j]
                     && !(w_g0 && (w_raddr[j] == w_waddr[w_i0]))
                     && !(w_g1 && (w_raddr[j] == w_waddr[w_i1]));
        end
    end

    assign w_rgrant_any = |w_rreq;
    assign w_rsel       = w_rreq[r_rp] ? r_rp : ~r_rp;

    always_comb begin
        w_rgrant = '0;
        if (w_rgrant_any) begin
            w_rgrant[w_rsel] = 1'b1;
        end
    end

    assign wr_req_ready = w_wgrant;
    assign rd_req_ready = w_rgrant;

    assign wr0_en   = w_init_en | w_g0;
    assign wr1_en   = w_init_en | w_g1;
    assign wr0_addr = w_init_en ? {1'b0, r_cnt} : (w_g0 ? w_waddr[w_i0] : '0);
    assign wr1_addr = w_init_en ? {1'b1, r_cnt} : (w_g1 ? w_waddr[w_i1] : '0);
    assign wr0_data = w_g0 ? w_wdata[w_i0] : '0;
    assign wr1_data = w_g1 ? w_wdata[w_i1] : '0;

    assign rd0_en   = w_rgrant_any;
    assign rd0_addr = w_rgrant_any ? w_raddr[w_rsel] : '0;

    assign rd_rsp_valid = r_rsp_vld_p1;
    assign rd_rsp_data  = rd0_data;
    assign init_done    = (r_state == ST_RUN);

    // Stage p0 -> p1: BRAM read latency is one cycle, so the response
    // valid simply trails the read grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_cnt        <= '0;
            r_wp         <= 2'd0;
            r_rp         <= 1'b0;
            r_rsp_vld_p1 <= '0;
        end else begin
            r_rsp_vld_p1 <= w_rgrant;
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (&r_cnt) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (clr_req) begin
                        r_state <= ST_INIT;
                        r_cnt   <= '0;
                    end else begin
                        r_wp <= w_wp_nxt;
                        if (w_rgrant_any) begin
                            r_rp <= ~w_rsel;
                        end
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lvt_bram_arbiter.sv
// Bench for lvt_bram_arbiter: directed scenarios plus a randomized run
// against a behavioural arbitration/memory model.
module tb_lvt_bram_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int HALF = 128;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      wr_req_valid;
    logic [3:0]      wr_req_ready;
    logic [4*AW-1:0] wr_req_addr;
    logic [4*DW-1:0] wr_req_data;
    logic [1:0]      rd_req_valid;
    logic [1:0]      rd_req_ready;
    logic [2*AW-1:0] rd_req_addr;
    logic [1:0]      rd_rsp_valid;
    logic [DW-1:0]   rd_rsp_data;
    logic            clr_req;
    logic            init_done;
    logic [AW-1:0]   wr0_addr, wr1_addr, rd0_addr;
    logic [DW-1:0]   wr0_data, wr1_data, rd0_data;
    logic            wr0_en, wr1_en, rd0_en;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] ref_mem [256];

    always #5 clk = ~clk;

    lvt_bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .clr_req      (clr_req),
        .init_done    (init_done),
        .wr0_addr     (wr0_addr),
        .wr1_addr     (wr1_addr),
        .wr0_data     (wr0_data),
        .wr1_data     (wr1_data),
        .wr0_en       (wr0_en),
        .wr1_en       (wr1_en),
        .rd0_addr     (rd0_addr),
        .rd0_en       (rd0_en),
        .rd0_data     (rd0_data)
    );

    // Simple dual-write, single synchronous-read BRAM.
    always @(posedge clk) begin
        if (wr0_en) mem[wr0_addr] <= wr0_data;
        if (wr1_en) mem[wr1_addr] <= wr1_data;
        if (rd0_en) rd0_data <= mem[rd0_addr];
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        wr_req_valid = '0;
        rd_req_valid = '0;
        clr_req      = 1'b0;
    endtask

    task automatic set_wr(input int i, input int a, input int d);
        wr_req_valid[i]            = 1'b1;
        wr_req_addr[i*AW +: AW]    = AW'(a);
        wr_req_data[i*DW +: DW]    = DW'(d);
    endtask

    task automatic set_rd(input int j, input int a);
        rd_req_valid[j]         = 1'b1;
        rd_req_addr[j*AW +: AW] = AW'(a);
    endtask

    // Called in the first INIT cycle; walks the clear sweep, pulsing clr_req
    // mid-way (it must be ignored) and holding all requests (none granted).
    task automatic test_init_sweep(input string name);
        int cyc;
        cyc = 0;
        wr_req_valid = 4'hF;
        rd_req_valid = 2'b11;
        #1;
        while (init_done !== 1'b1 && cyc < 300) begin
            n_tests++;
            if (wr0_en !== 1'b1 || wr1_en !== 1'b1 || wr0_addr !== AW'(cyc) ||
                wr1_addr !== AW'(cyc + HALF) || wr0_data !== 8'd0 || wr1_data !== 8'd0 ||
                wr_req_ready !== 4'b0000 || rd_req_ready !== 2'b00 || rd0_en !== 1'b0) begin
                n_fail++;
                $display("FAIL %s init cycle %0d: en=%b%b a0=%0d a1=%0d d=%0d/%0d wrdy=%b rrdy=%b rd0_en=%b, required en=11 a0=%0d a1=%0d d=0/0 rdy=0",
                         name, cyc, wr0_en, wr1_en, wr0_addr, wr1_addr, wr0_data, wr1_data,
                         wr_req_ready, rd_req_ready, rd0_en, cyc % 256, (cyc + HALF) % 256);
            end
            clr_req = (cyc >= 10 && cyc < 20);
            tick();
            cyc++;
        end
        idle();
        #1;
        n_tests++;
        if (cyc != HALF) begin
            n_fail++;
            $display("FAIL %s init length: actual %0d cycles, required %0d", name, cyc, HALF);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        wr_req_addr = '0;
        wr_req_data = '0;
        rd_req_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (wr0_en !== 1'b0 || wr1_en !== 1'b0 || rd0_en !== 1'b0 ||
            init_done !== 1'b0 || rd_rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL reset state: en=%b%b%b init_done=%b rsp=%b, required all 0",
                     wr0_en, wr1_en, rd0_en, init_done, rd_rsp_valid);
        end
        rst = 1'b0;
        #1;
        test_init_sweep("reset");
        set_rd(0, 5);
        #1;
        n_tests++;
        if (rd_req_ready !== 2'b01 || rd0_en !== 1'b1 || rd0_addr !== 8'd5) begin
            n_fail++;
            $display("FAIL read5 grant: rrdy=%b en=%b addr=%0d, required 01 1 5",
                     rd_req_ready, rd0_en, rd0_addr);
        end
        tick();
        idle();
        n_tests++;
        if (rd_rsp_valid !== 2'b01 || rd_rsp_data !== 8'd0) begin
            n_fail++;
            $display("FAIL read5 rsp: valid=%b data=%0d, required 01 0", rd_rsp_valid, rd_rsp_data);
        end
    endtask

    task automatic test_idle_ports();
        wr_req_addr = '1;
        wr_req_data = '1;
        rd_req_addr = '1;
        tick();
        n_tests++;
        if (rd_rsp_valid !== 2'b00 || wr0_en !== 1'b0 || wr1_en !== 1'b0 || rd0_en !== 1'b0 ||
            wr0_addr !== 8'd0 || wr1_addr !== 8'd0 || wr0_data !== 8'd0 || wr1_data !== 8'd0 ||
            rd0_addr !== 8'd0 || wr_req_ready !== 4'b0000 || init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL idle ports: rsp=%b en=%b%b%b a=%0d/%0d/%0d d=%0d/%0d wrdy=%b done=%b, required zeros and done=1",
                     rd_rsp_valid, wr0_en, wr1_en, rd0_en, wr0_addr, wr1_addr, rd0_addr,
                     wr0_data, wr1_data, wr_req_ready, init_done);
        end
    endtask

    task automatic test_dual_write();
        set_wr(0, 10, 5);
        set_wr(1, 20, 10);
        #1;
        n_tests++;
        if (wr_req_ready !== 4'b0011 || wr0_en !== 1'b1 || wr1_en !== 1'b1 ||
            wr0_addr !== 8'd10 || wr0_data !== 8'd5 || wr1_addr !== 8'd20 || wr1_data !== 8'd10) begin
            n_fail++;
            $display("FAIL dual write: wrdy=%b p0=%0d/%0d p1=%0d/%0d, required 0011 10/5 20/10",
                     wr_req_ready, wr0_addr, wr0_data, wr1_addr, wr1_data);
        end
        tick();
        idle();
        set_rd(1, 10);
        #1;
        n_tests++;
        if (rd_req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL dual read grant: rrdy=%b, required 10", rd_req_ready);
        end
        tick();
        idle();
        n_tests++;
        if (rd_rsp_valid !== 2'b10 || rd_rsp_data !== 8'd5) begin
            n_fail++;
            $display("FAIL dual read rsp: valid=%b data=%0d, required 10 5", rd_rsp_valid, rd_rsp_data);
        end
    endtask

    task automatic test_same_addr();
        set_wr(3, 200, 1);
        #1;
        n_tests++;
        if (wr_req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL same-addr prep: wrdy=%b, required 1000", wr_req_ready);
        end
        tick();
        idle();
        set_wr(0, 50, 25);
        set_wr(2, 50, 30);
        #1;
        n_tests++;
        if (wr_req_ready !== 4'b0001 || wr0_addr !== 8'd50 || wr0_data !== 8'd25 || wr1_en !== 1'b0) begin
            n_fail++;
            $display("FAIL same-addr cycle N: wrdy=%b p0=%0d/%0d wr1_en=%b, required 0001 50/25 0",
                     wr_req_ready, wr0_addr, wr0_data, wr1_en);
        end
        tick();
        wr_req_valid[0] = 1'b0;
        #1;
        n_tests++;
        if (wr_req_ready !== 4'b0100 || wr0_addr !== 8'd50 || wr0_data !== 8'd30) begin
            n_fail++;
            $display("FAIL same-addr cycle N+1: wrdy=%b p0=%0d/%0d, required 0100 50/30",
                     wr_req_ready, wr0_addr, wr0_data);
        end
        tick();
        idle();
        set_rd(0, 50);
        #1;
        n_tests++;
        if (rd_req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL same-addr read grant: rrdy=%b, required 01", rd_req_ready);
        end
        tick();
        idle();
        n_tests++;
        if (rd_rsp_valid !== 2'b01 || rd_rsp_data !== 8'd30) begin
            n_fail++;
            $display("FAIL same-addr read rsp: valid=%b data=%0d, required 01 30", rd_rsp_valid, rd_rsp_data);
        end
    endtask

    task automatic test_all_four();
        logic [3:0] exp_rdy [3];
        int         exp_a0  [3];
        exp_rdy = '{4'b0011, 4'b1100, 4'b0011};
        exp_a0  = '{100, 102, 100};
        set_wr(3, 201, 2);
        #1;
        n_tests++;
        if (wr_req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL all-four prep: wrdy=%b, required 1000", wr_req_ready);
        end
        tick();
        idle();
        for (int i = 0; i < 4; i++) set_wr(i, 100 + i, 60 + i);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (wr_req_ready !== exp_rdy[c] || wr0_addr !== AW'(exp_a0[c])) begin
                n_fail++;
                $display("FAIL all-four pair %0d: wrdy=%b p0=%0d, required %b %0d",
                         c, wr_req_ready, wr0_addr, exp_rdy[c], exp_a0[c]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_rd_conflict();
        set_wr(0, 70, 35);
        set_rd(1, 70);
        #1;
        n_tests++;
        if (wr_req_ready !== 4'b0001 || rd_req_ready !== 2'b00 || rd0_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rd conflict stall: wrdy=%b rrdy=%b rd0_en=%b, required 0001 00 0",
                     wr_req_ready, rd_req_ready, rd0_en);
        end
        tick();
        wr_req_valid = '0;
        #1;
        n_tests++;
        if (rd_req_ready !== 2'b10 || rd0_addr !== 8'd70) begin
            n_fail++;
            $display("FAIL rd conflict retry: rrdy=%b addr=%0d, required 10 70", rd_req_ready, rd0_addr);
        end
        tick();
        idle();
        n_tests++;
        if (rd_rsp_valid !== 2'b10 || rd_rsp_data !== 8'd35) begin
            n_fail++;
            $display("FAIL rd conflict rsp: valid=%b data=%0d, required 10 35", rd_rsp_valid, rd_rsp_data);
        end
    endtask

    task automatic test_clear();
        set_wr(1, 90, 45);
        set_rd(0, 70);
        #1;
        n_tests++;
        if (wr_req_ready !== 4'b0010 || rd_req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL pre-clear grants: wrdy=%b rrdy=%b, required 0010 01", wr_req_ready, rd_req_ready);
        end
        tick();
        idle();
        clr_req      = 1'b1;
        wr_req_valid = 4'hF;
        rd_req_valid = 2'b11;
        #1;
        n_tests++;
        if (wr_req_ready !== 4'b0000 || rd_req_ready !== 2'b00 || wr0_en !== 1'b0 ||
            init_done !== 1'b1 || rd_rsp_valid !== 2'b01 || rd_rsp_data !== 8'd35) begin
            n_fail++;
            $display("FAIL clear cycle: wrdy=%b rrdy=%b wr0_en=%b done=%b rsp=%b data=%0d, required 0000 00 0 1 01 35",
                     wr_req_ready, rd_req_ready, wr0_en, init_done, rd_rsp_valid, rd_rsp_data);
        end
        tick();
        clr_req = 1'b0;
        test_init_sweep("clear");
        set_rd(1, 90);
        #1;
        n_tests++;
        if (rd_req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL post-clear read grant: rrdy=%b, required 10", rd_req_ready);
        end
        tick();
        idle();
        n_tests++;
        if (rd_rsp_valid !== 2'b10 || rd_rsp_data !== 8'd0) begin
            n_fail++;
            $display("FAIL post-clear read: valid=%b data=%0d, required 10 0", rd_rsp_valid, rd_rsp_data);
        end
    endtask

    task automatic test_reset_mid_init();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (40) tick();
        n_tests++;
        if (wr0_addr !== 8'd40 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid-init position: a0=%0d done=%b, required 40 0", wr0_addr, init_done);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (wr0_en !== 1'b0 || wr1_en !== 1'b0 || rd0_en !== 1'b0 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async reset: en=%b%b%b done=%b, required 000 0", wr0_en, wr1_en, rd0_en, init_done);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        test_init_sweep("mid-init reset");
    endtask

    task automatic test_random();
        int m_wp, m_rp, g0, g1, sel;
        int va[4], aa[4], da[4], rv[2], ra[2];
        bit ok[2];
        logic [3:0] ew;
        logic [1:0] er, exp_rsp_vld;
        logic [DW-1:0] exp_rsp_data;
        int ea0, ed0, ea1, ed1, era;
        m_wp = 0;
        m_rp = 0;
        exp_rsp_vld  = 2'b00;
        exp_rsp_data = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        for (int it = 0; it < 400; it++) begin
            n_tests++;
            if (rd_rsp_valid !== exp_rsp_vld || (exp_rsp_vld != 2'b00 && rd_rsp_data !== exp_rsp_data)) begin
                n_fail++;
                $display("FAIL random rsp %0d: valid=%b data=%0d, required %b %0d",
                         it, rd_rsp_valid, rd_rsp_data, exp_rsp_vld, exp_rsp_data);
            end
            for (int i = 0; i < 4; i++) begin
                va[i] = $urandom_range(0, 1);
                aa[i] = $urandom_range(0, 7);
                da[i] = $urandom_range(0, 255);
                wr_req_valid[i]         = (va[i] != 0);
                wr_req_addr[i*AW +: AW] = AW'(aa[i]);
                wr_req_data[i*DW +: DW] = DW'(da[i]);
            end
            for (int j = 0; j < 2; j++) begin
                rv[j] = $urandom_range(0, 1);
                ra[j] = $urandom_range(0, 7);
                rd_req_valid[j]         = (rv[j] != 0);
                rd_req_addr[j*AW +: AW] = AW'(ra[j]);
            end
            #1;
            g0 = -1;
            for (int k = 0; k < 4; k++)
                if (g0 < 0 && va[(m_wp + k) % 4] != 0) g0 = (m_wp + k) % 4;
            g1 = -1;
            if (g0 >= 0)
                for (int k = 1; k < 4; k++)
                    if (g1 < 0 && va[(g0 + k) % 4] != 0 && aa[(g0 + k) % 4] != aa[g0]) g1 = (g0 + k) % 4;
            ew = '0;
            if (g0 >= 0) ew[g0] = 1'b1;
            if (g1 >= 0) ew[g1] = 1'b1;
            for (int j = 0; j < 2; j++)
                ok[j] = (rv[j] != 0) && !(g0 >= 0 && ra[j] == aa[g0]) && !(g1 >= 0 && ra[j] == aa[g1]);
            sel = -1;
            if (ok[m_rp]) sel = m_rp;
            else if (ok[1 - m_rp]) sel = 1 - m_rp;
            er = '0;
            if (sel >= 0) er[sel] = 1'b1;
            ea0 = (g0 >= 0) ? aa[g0] : 0;
            ed0 = (g0 >= 0) ? da[g0] : 0;
            ea1 = (g1 >= 0) ? aa[g1] : 0;
            ed1 = (g1 >= 0) ? da[g1] : 0;
            era = (sel >= 0) ? ra[sel] : 0;
            n_tests++;
            if (wr_req_ready !== ew || rd_req_ready !== er || wr0_en !== (g0 >= 0) || wr1_en !== (g1 >= 0) ||
                rd0_en !== (sel >= 0) || wr0_addr !== AW'(ea0) || wr0_data !== DW'(ed0) ||
                wr1_addr !== AW'(ea1) || wr1_data !== DW'(ed1) || rd0_addr !== AW'(era)) begin
                n_fail++;
                $display("FAIL random grant %0d: wrdy=%b rrdy=%b p0=%0d/%0d p1=%0d/%0d rd=%0d, required %b %b %0d/%0d %0d/%0d %0d",
                         it, wr_req_ready, rd_req_ready, wr0_addr, wr0_data, wr1_addr, wr1_data, rd0_addr,
                         ew, er, ea0, ed0, ea1, ed1, era);
            end
            exp_rsp_vld = er;
            if (sel >= 0) exp_rsp_data = ref_mem[ra[sel]];
            if (g0 >= 0) ref_mem[aa[g0]] = DW'(da[g0]);
            if (g1 >= 0) ref_mem[aa[g1]] = DW'(da[g1]);
            if (g1 >= 0) m_wp = (g1 + 1) % 4;
            else if (g0 >= 0) m_wp = (g0 + 1) % 4;
            if (sel >= 0) m_rp = 1 - sel;
            tick();
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_ports();
        test_dual_write();
        test_same_addr();
        test_all_four();
        test_rd_conflict();
        test_clear();
        test_reset_mid_init();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
